id_ex_pipeline_reg: RTL and testbench

Pipeline register between decode and execute. Captures the decoded instruction (operand indices, operand data, immediate, control bits) each cycle and presents it to the EX stage and to `EX_hazard_checker`. Honours the hazard checker's `EX_stall` by holding its contents, and honours branch `flush` by inserting a bubble. Snoops the write-back port so held operand data never goes stale during multi-cycle stalls.

---
 rtl/id_ex_pipeline_reg.sv | 166 ++++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: decoded instruction to EX, with WB snoop, flush bubble and optional perf counters (ID_EX_PERF_CNT_EN).
// Latency: 1 cycle ID_* -> ID_EX_*; ID_hold is combinational (EX_stall & ~flush).
// Backpressure: EX_stall freezes contents (operand data still snooped from WB); flush overrides stall with a bubble.
module id_ex_pipeline_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_valid,
    input  logic [XLEN-1:0]   ID_pc,
    input  logic [REG_AW-1:0] ID_rs1,
    input  logic [REG_AW-1:0] ID_rs2,
    input  logic [REG_AW-1:0] ID_rd,
    input  logic [XLEN-1:0]   ID_rs1_data,
    input  logic [XLEN-1:0]   ID_rs2_data,
    input  logic [XLEN-1:0]   ID_imm,
    input  logic [6:0]        ID_opcode,
    input  logic [2:0]        ID_funct3,
    input  logic [6:0]        ID_funct7,
    input  logic              ID_regwrite,
    input  logic              ID_memtoreg,
    input  logic              ID_memwrite,
    input  logic              ID_alusrc,
    input  logic              EX_stall,
    input  logic              flush,
    input  logic              WB_regwrite,
    input  logic [REG_AW-1:0] WB_rd,
    input  logic [XLEN-1:0]   WB_data,
    output logic              ID_EX_valid,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic [REG_AW-1:0] ID_EX_rs1,
    output logic [REG_AW-1:0] ID_EX_rs2,
    output logic [REG_AW-1:0] ID_EX_rd,
    output logic [XLEN-1:0]   ID_EX_rs1_data,
    output logic [XLEN-1:0]   ID_EX_rs2_data,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [6:0]        ID_EX_opcode,
    output logic [2:0]        ID_EX_funct3,
    output logic [6:0]        ID_EX_funct7,
    output logic              ID_EX_regwrite,
    output logic              ID_EX_memtoreg,
    output logic              ID_EX_memwrite,
    output logic              ID_EX_alusrc,
    output logic              ID_hold,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    // Everything the EX stage sees, kept together so a bubble is simply '0.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic              alusrc;
    } id_ex_t;

    id_ex_t            stage_q;
    id_ex_t            load_dat;
    logic [XLEN-1:0]   hold_rs1_dat;
    logic [XLEN-1:0]   hold_rs2_dat;
    logic              wb_vld;

    // x0 writes are architecturally discarded, so they must never be snooped.
    assign wb_vld  = WB_regwrite && (WB_rd != '0);

    // The front end freezes only when the stall is not being overridden by a flush.
    assign ID_hold = EX_stall & ~flush;

    // Build the value captured on a normal advance, forwarding a same-cycle WB write.
    always_comb begin
        load_dat = '0;
        if (ID_valid) begin
            load_dat.valid    = 1'b1;
            load_dat.pc       = ID_pc;
            load_dat.rs1      = ID_rs1;
            load_dat.rs2      = ID_rs2;
            load_dat.rd       = ID_rd;
            load_dat.rs1_data = (wb_vld && WB_rd == ID_rs1) ? WB_data : ID_rs1_data;
            load_dat.rs2_data = (wb_vld && WB_rd == ID_rs2) ? WB_data : ID_rs2_data;
            load_dat.imm      = ID_imm;
            load_dat.opcode   = ID_opcode;
            load_dat.funct3   = ID_funct3;
            load_dat.funct7   = ID_funct7;
            load_dat.regwrite = ID_regwrite && (ID_rd != '0);
            load_dat.memtoreg = ID_memtoreg;
            load_dat.memwrite = ID_memwrite;
            load_dat.alusrc   = ID_alusrc;
        end
    end

    // Refresh held operands with any WB write to the held source registers.
    always_comb begin
        hold_rs1_dat = stage_q.rs1_data;
        hold_rs2_dat = stage_q.rs2_data;
        if (wb_vld && WB_rd == stage_q.rs1) hold_rs1_dat = WB_data;
        if (wb_vld && WB_rd == stage_q.rs2) hold_rs2_dat = WB_data;
    end

    // Stage register: reset, then flush, then stall (with snoop), then load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (EX_stall) begin
            stage_q.rs1_data <= hold_rs1_dat;
            stage_q.rs2_data <= hold_rs2_dat;
        end else begin
            stage_q <= load_dat;
        end
    end

    assign ID_EX_valid    = stage_q.valid;
    assign ID_EX_pc       = stage_q.pc;
    assign ID_EX_rs1      = stage_q.rs1;
    assign ID_EX_rs2      = stage_q.rs2;
    assign ID_EX_rd       = stage_q.rd;
    assign ID_EX_rs1_data = stage_q.rs1_data;
    assign ID_EX_rs2_data = stage_q.rs2_data;
    assign ID_EX_imm      = stage_q.imm;
    assign ID_EX_opcode   = stage_q.opcode;
    assign ID_EX_funct3   = stage_q.funct3;
    assign ID_EX_funct7   = stage_q.funct7;
    assign ID_EX_regwrite = stage_q.regwrite;
    assign ID_EX_memtoreg = stage_q.memtoreg;
    assign ID_EX_memwrite = stage_q.memwrite;
    assign ID_EX_alusrc   = stage_q.alusrc;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters; a flush cycle is not counted as a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (EX_stall && !flush && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: reset, load, stall+snoop, flush, x0, counters.
// Latency: checks one edge after each stimulus, sampled 1 ns after the rising edge.
// Backpressure: exercises EX_stall hold and flush-over-stall priority.
module tb_id_ex_pipeline_reg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ID_valid;
    logic [XLEN-1:0]   ID_pc;
    logic [REG_AW-1:0] ID_rs1, ID_rs2, ID_rd;
    logic [XLEN-1:0]   ID_rs1_data, ID_rs2_data, ID_imm;
    logic [6:0]        ID_opcode;
    logic [2:0]        ID_funct3;
    logic [6:0]        ID_funct7;
    logic              ID_regwrite, ID_memtoreg, ID_memwrite, ID_alusrc;
    logic              EX_stall, flush;
    logic              WB_regwrite;
    logic [REG_AW-1:0] WB_rd;
    logic [XLEN-1:0]   WB_data;
    logic              ID_EX_valid;
    logic [XLEN-1:0]   ID_EX_pc;
    logic [REG_AW-1:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [XLEN-1:0]   ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [6:0]        ID_EX_opcode;
    logic [2:0]        ID_EX_funct3;
    logic [6:0]        ID_EX_funct7;
    logic              ID_EX_regwrite, ID_EX_memtoreg, ID_EX_memwrite, ID_EX_alusrc;
    logic              ID_hold;
    logic [CNT_W-1:0]  stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_valid(ID_valid), .ID_pc(ID_pc),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
        .ID_opcode(ID_opcode), .ID_funct3(ID_funct3), .ID_funct7(ID_funct7),
        .ID_regwrite(ID_regwrite), .ID_memtoreg(ID_memtoreg),
        .ID_memwrite(ID_memwrite), .ID_alusrc(ID_alusrc),
        .EX_stall(EX_stall), .flush(flush),
        .WB_regwrite(WB_regwrite), .WB_rd(WB_rd), .WB_data(WB_data),
        .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_opcode(ID_EX_opcode),
        .ID_EX_funct3(ID_EX_funct3), .ID_EX_funct7(ID_EX_funct7),
        .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memtoreg(ID_EX_memtoreg),
        .ID_EX_memwrite(ID_EX_memwrite), .ID_EX_alusrc(ID_EX_alusrc),
        .ID_hold(ID_hold), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ID_valid = 1'b1; ID_pc = 32'h55; ID_rs1 = 5'd1; ID_rs2 = 5'd2;
        ID_rd = 5'd3; ID_rs1_data = 32'h1; ID_rs2_data = 32'h2; ID_imm = 32'h3;
        ID_opcode = 7'h13; ID_funct3 = 3'd1; ID_funct7 = 7'd1; ID_regwrite = 1'b1;
        ID_memtoreg = 1'b1; ID_memwrite = 1'b1; ID_alusrc = 1'b1;
        EX_stall = 1'b0; flush = 1'b0; WB_regwrite = 1'b0; WB_rd = '0; WB_data = '0;

        // Reset: inputs are live but must be ignored.
        tick(); tick();
        check("rst_valid", ID_EX_valid, 0);
        check("rst_pc", ID_EX_pc, 0);
        check("rst_rd", ID_EX_rd, 0);
        check("rst_regwrite", ID_EX_regwrite, 0);
        check("rst_memwrite", ID_EX_memwrite, 0);
        check("rst_rs1_data", ID_EX_rs1_data, 0);
        check("rst_stall_cnt", stall_cycles, 0);
        check("rst_flush_cnt", flush_count, 0);

        // First load after reset.
        rst_n = 1'b1; ID_pc = 32'h100; ID_rd = 5'd5; ID_regwrite = 1'b1;
        ID_rs1 = 5'd7; ID_rs1_data = 32'h11; ID_rs2 = 5'd2; ID_rs2_data = 32'h22;
        ID_imm = 32'hFFFF_FFFC; ID_opcode = 7'h33; ID_funct3 = 3'd5; ID_funct7 = 7'h20;
        ID_memtoreg = 1'b1; ID_memwrite = 1'b0; ID_alusrc = 1'b1;
        tick();
        check("ld_valid", ID_EX_valid, 1);
        check("ld_pc", ID_EX_pc, 32'h100);
        check("ld_rd", ID_EX_rd, 5);
        check("ld_regwrite", ID_EX_regwrite, 1);
        check("ld_rs1", ID_EX_rs1, 7);
        check("ld_rs1_data", ID_EX_rs1_data, 32'h11);
        check("ld_rs2_data", ID_EX_rs2_data, 32'h22);
        check("ld_imm", ID_EX_imm, 32'hFFFF_FFFC);
        check("ld_opcode", ID_EX_opcode, 7'h33);
        check("ld_funct3", ID_EX_funct3, 5);
        check("ld_funct7", ID_EX_funct7, 7'h20);
        check("ld_memtoreg", ID_EX_memtoreg, 1);
        check("ld_memwrite", ID_EX_memwrite, 0);
        check("ld_alusrc", ID_EX_alusrc, 1);

        // Three-cycle stall; WB hits held rs1 in the second cycle.
        ID_pc = 32'h104; ID_rd = 5'd6; ID_rs1 = 5'd8; ID_rs1_data = 32'h99;
        EX_stall = 1'b1;
        settle(); check("st1_hold", ID_hold, 1);
        tick();
        check("st1_pc", ID_EX_pc, 32'h100);
        check("st1_rs1_data", ID_EX_rs1_data, 32'h11);
        WB_regwrite = 1'b1; WB_rd = 5'd7; WB_data = 32'hAB;
        settle(); check("st2_hold", ID_hold, 1);
        tick();
        check("st2_pc", ID_EX_pc, 32'h100);
        check("st2_snoop", ID_EX_rs1_data, 32'hAB);
        check("st2_rs2_data", ID_EX_rs2_data, 32'h22);
        WB_regwrite = 1'b0;
        settle(); check("st3_hold", ID_hold, 1);
        tick();
        check("st3_pc", ID_EX_pc, 32'h100);
        check("st3_rs1_data", ID_EX_rs1_data, 32'hAB);
        EX_stall = 1'b0;
        settle(); check("adv_hold", ID_hold, 0);
        tick();
        check("adv_pc", ID_EX_pc, 32'h104);
        check("adv_rd", ID_EX_rd, 6);
        check("adv_rs1_data", ID_EX_rs1_data, 32'h99);
        check("cnt_stall3", stall_cycles, PERF ? 3 : 0);

        // Flush overrides stall and discards a matching WB snoop.
        flush = 1'b1; EX_stall = 1'b1;
        WB_regwrite = 1'b1; WB_rd = 5'd8; WB_data = 32'h77;
        settle(); check("fl_hold", ID_hold, 0);
        tick();
        check("fl_valid", ID_EX_valid, 0);
        check("fl_regwrite", ID_EX_regwrite, 0);
        check("fl_pc", ID_EX_pc, 0);
        check("fl_rd", ID_EX_rd, 0);
        check("fl_rs1_data", ID_EX_rs1_data, 0);
        check("cnt_after_fl_stall", stall_cycles, PERF ? 3 : 0);
        check("cnt_after_fl_flush", flush_count, PERF ? 1 : 0);
        flush = 1'b0; EX_stall = 1'b0;

        // x0: regwrite suppressed, WB to x0 not snooped.
        ID_pc = 32'h108; ID_rd = 5'd0; ID_regwrite = 1'b1;
        ID_rs1 = 5'd0; ID_rs1_data = 32'h5A;
        WB_regwrite = 1'b1; WB_rd = 5'd0; WB_data = 32'hFF;
        tick();
        check("x0_valid", ID_EX_valid, 1);
        check("x0_regwrite", ID_EX_regwrite, 0);
        check("x0_rs1_data", ID_EX_rs1_data, 32'h5A);

        // Load-time snoop on rs2.
        ID_pc = 32'h10C; ID_rd = 5'd4; ID_rs2 = 5'd3; ID_rs2_data = 32'h1;
        WB_regwrite = 1'b1; WB_rd = 5'd3; WB_data = 32'h22;
        tick();
        check("lsn_rs2_data", ID_EX_rs2_data, 32'h22);
        check("lsn_rs1_data", ID_EX_rs1_data, 32'h5A);
        check("lsn_regwrite", ID_EX_regwrite, 1);
        WB_regwrite = 1'b0;
        tick();
        check("nosn_rs2_data", ID_EX_rs2_data, 32'h1);

        // ID_valid=0 captures a bubble.
        ID_valid = 1'b0; ID_pc = 32'h200;
        tick();
        check("bub_valid", ID_EX_valid, 0);
        check("bub_pc", ID_EX_pc, 0);
        check("bub_regwrite", ID_EX_regwrite, 0);

        // Reset mid-stall wins over EX_stall.
        ID_valid = 1'b1; ID_pc = 32'h300; ID_rd = 5'd9;
        tick();
        check("pre_rst_pc", ID_EX_pc, 32'h300);
        EX_stall = 1'b1; rst_n = 1'b0;
        tick();
        check("mrst_valid", ID_EX_valid, 0);
        check("mrst_pc", ID_EX_pc, 0);
        check("mrst_cnt", stall_cycles, 0);
        rst_n = 1'b1;

        // Counters: 4 stalls then 2 flushes.
        for (int i = 0; i < 4; i++) tick();
        EX_stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        flush = 1'b0;
        check("cnt_stall4", stall_cycles, PERF ? 4 : 0);
        check("cnt_flush2", flush_count, PERF ? 2 : 0);

        // Saturation at all-ones (CNT_W=4).
        EX_stall = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("sat_stall", stall_cycles, PERF ? 15 : 0);
        EX_stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check("sat_flush", flush_count, PERF ? 15 : 0);
        flush = 1'b0; EX_stall = 1'b1;
        tick(); tick();
        check("sat_stall_hold", stall_cycles, PERF ? 15 : 0);
        check("sat_flush_hold", flush_count, PERF ? 15 : 0);
        EX_stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
